noc_switch_allocator: RTL and testbench

- Per-output-port switch allocator that sequences the router crossbar.
- Each cycle it picks at most one input per output port. It uses round-robin priority and wormhole packet locking, and honours downstream credit.
- It drives the crossbar select vector `granted_dest_port_all` (per-input one-hot, sender port removed unless self-loop is enabled).
- It also returns per-input grant strobes that pop the input buffers.

---
 rtl/noc_switch_allocator.sv | 149 ++++++++++++++
 tb/tb_noc_switch_allocator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_switch_allocator.sv
// Per-output switch allocator: round-robin arbitration with wormhole locking and credit gating.
// Grants are combinational from current requests and registered per-output lock/priority state.
module noc_switch_allocator #(
    parameter int    P            = 5,
    parameter string SELF_LOOP_EN = "NO",
    parameter string PKT_LOCK     = "YES",
    localparam int   P_1          = (SELF_LOOP_EN == "YES") ? P : P - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P-1:0]       flit_valid_all,
    input  logic [P-1:0]       hdr_flag_all,
    input  logic [P-1:0]       tail_flag_all,
    input  logic [P*P_1-1:0]   dest_port_all,
    input  logic [P-1:0]       outport_ready_all,
    output logic [P*P_1-1:0]   granted_dest_port_all,
    output logic [P-1:0]       inport_granted_all,
    output logic [P-1:0]       outport_busy_all
);

    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam bit SL = (SELF_LOOP_EN == "YES");
    localparam bit LK = (PKT_LOCK == "YES");

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t   r_state     [P];
    lock_state_t   w_state_nxt [P];
    logic [LW-1:0] r_owner     [P];
    logic [LW-1:0] w_owner_nxt [P];
    logic [LW-1:0] r_rr_last   [P];
    logic [LW-1:0] w_rr_nxt    [P];

    // Indexed [output][input].
    logic [P-1:0]  w_req  [P];
    logic [P-1:0]  w_cand [P];
    logic [P-1:0]  w_gnt  [P];
    logic [P-1:0]  w_owner_locked;

    // Local bit k of input j addresses output k below j, k+1 at or above j (sender removed).
    always_comb begin
        int w_o;
        w_o = 0;
        for (int o = 0; o < P; o++) begin
            w_req[o] = '0;
        end
        for (int j = 0; j < P; j++) begin
            for (int k = 0; k < P_1; k++) begin
                w_o = (SL || k < j) ? k : k + 1;
                w_req[w_o][j] = dest_port_all[j*P_1 + k];
            end
        end
    end

    always_comb begin
        w_owner_locked = '0;
        for (int o = 0; o < P; o++) begin
            if (r_state[o] == LOCKED) begin
                w_owner_locked[r_owner[o]] = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        logic w_found;
        int   w_idx;
        w_found = 1'b0;
        w_idx   = 0;
        for (int o = 0; o < P; o++) begin
            w_gnt[o]       = '0;
            w_state_nxt[o] = r_state[o];
            w_owner_nxt[o] = r_owner[o];
            w_rr_nxt[o]    = r_rr_last[o];
            w_cand[o]      = flit_valid_all & w_req[o] & ~w_owner_locked
                           & (LK ? hdr_flag_all : {P{1'b1}});
            w_found        = 1'b0;

            case (r_state[o])
                IDLE: begin
                    if (outport_ready_all[o]) begin
                        for (int i = 1; i <= P; i++) begin
                            w_idx = (int'(r_rr_last[o]) + i) % P;
                            if (!w_found && w_cand[o][w_idx]) begin
                                w_found           = 1'b1;
                                w_gnt[o][w_idx]   = 1'b1;
                                w_rr_nxt[o]       = LW'(w_idx);
                                if (LK && !tail_flag_all[w_idx]) begin
                                    w_state_nxt[o] = LOCKED;
                                    w_owner_nxt[o] = LW'(w_idx);
                                end
                            end
                        end
                    end
                end
                LOCKED: begin
                    // The owner's dest and hdr bits are irrelevant once the path is held.
                    if (flit_valid_all[r_owner[o]] && outport_ready_all[o]) begin
                        w_gnt[o][r_owner[o]] = 1'b1;
                        if (tail_flag_all[r_owner[o]]) begin
                            w_state_nxt[o] = IDLE;
                        end
                    end
                end
                default: ;
            endcase

            if (reset) begin
                w_gnt[o] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every output updates from pre-edge values.
    always_ff @(posedge clk) begin
        for (int o = 0; o < P; o++) begin
            if (reset) begin
                r_state[o]   <= IDLE;
                r_owner[o]   <= '0;
                r_rr_last[o] <= LW'(P - 1);
            end else begin
                r_state[o]   <= w_state_nxt[o];
                r_owner[o]   <= w_owner_nxt[o];
                r_rr_last[o] <= w_rr_nxt[o];
            end
        end
    end

    always_comb begin
        int w_o;
        w_o                   = 0;
        granted_dest_port_all = '0;
        inport_granted_all    = '0;
        for (int j = 0; j < P; j++) begin
            for (int k = 0; k < P_1; k++) begin
                w_o = (SL || k < j) ? k : k + 1;
                granted_dest_port_all[j*P_1 + k] = w_gnt[w_o][j];
                inport_granted_all[j] = inport_granted_all[j] | w_gnt[w_o][j];
            end
        end
        for (int o = 0; o < P; o++) begin
            outport_busy_all[o] = (r_state[o] == LOCKED);
        end
    end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Bench for noc_switch_allocator: directed scenarios plus random traffic against a
// packet-level reference model (locks, owners and round-robin pointers as plain ints).
module tb_noc_switch_allocator;

    localparam int P   = 5;
    localparam int P1  = 4;
    localparam int P1S = 5;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [P-1:0]      valid, hdr, tail, ready;
    logic [P*P1-1:0]   dest, gdp;
    logic [P-1:0]      ing, busy;

    logic [P-1:0]      s_valid, s_hdr, s_tail, s_ready, s_ing, s_busy;
    logic [P*P1S-1:0]  s_dest, s_gdp;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_locked [P];
    int m_owner  [P];
    int m_rr     [P];
    int m_win    [P];

    always #5 clk = ~clk;

    noc_switch_allocator #(.P(P), .SELF_LOOP_EN("NO"), .PKT_LOCK("YES")) u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .flit_valid_all        (valid),
        .hdr_flag_all          (hdr),
        .tail_flag_all         (tail),
        .dest_port_all         (dest),
        .outport_ready_all     (ready),
        .granted_dest_port_all (gdp),
        .inport_granted_all    (ing),
        .outport_busy_all      (busy)
    );

    noc_switch_allocator #(.P(P), .SELF_LOOP_EN("YES"), .PKT_LOCK("YES")) u_dut_sl (
        .clk                   (clk),
        .reset                 (reset),
        .flit_valid_all        (s_valid),
        .hdr_flag_all          (s_hdr),
        .tail_flag_all         (s_tail),
        .dest_port_all         (s_dest),
        .outport_ready_all     (s_ready),
        .granted_dest_port_all (s_gdp),
        .inport_granted_all    (s_ing),
        .outport_busy_all      (s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bitpos(input int j, input int o);
        return j*P1 + ((o > j) ? o - 1 : o);
    endfunction

    task automatic send(input int j, input int o, input bit h, input bit t);
        valid[j] = 1'b1;
        hdr[j]   = h;
        tail[j]  = t;
        for (int k = 0; k < P1; k++) dest[j*P1 + k] = 1'b0;
        dest[bitpos(j, o)] = 1'b1;
    endtask

    task automatic clr(input int j);
        valid[j] = 1'b0;
        hdr[j]   = 1'b0;
        tail[j]  = 1'b0;
        for (int k = 0; k < P1; k++) dest[j*P1 + k] = 1'b0;
    endtask

    task automatic clr_all();
        for (int j = 0; j < P; j++) clr(j);
        ready = '1;
    endtask

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_locked[o] = 1'b0;
            m_owner[o]  = 0;
            m_rr[o]     = P - 1;
            m_win[o]    = -1;
        end
    endtask

    // Called just after the falling edge: predicts this cycle's grants and compares.
    task automatic eval_cycle();
        logic [P*P1-1:0] e_gdp;
        logic [P-1:0]    e_ing, e_busy;
        bit              owned [P];
        int              best_d, d;
        #1;
        e_gdp = '0;
        e_ing = '0;
        e_busy = '0;
        for (int j = 0; j < P; j++) owned[j] = 1'b0;
        for (int o = 0; o < P; o++) begin
            e_busy[o] = m_locked[o];
            if (m_locked[o]) owned[m_owner[o]] = 1'b1;
        end
        for (int o = 0; o < P; o++) begin
            m_win[o] = -1;
            if (reset || !ready[o]) continue;
            if (m_locked[o]) begin
                if (valid[m_owner[o]]) m_win[o] = m_owner[o];
            end else begin
                best_d = P;
                for (int j = 0; j < P; j++) begin
                    if (j != o && valid[j] && hdr[j] && !owned[j] && dest[bitpos(j, o)]) begin
                        d = (j - m_rr[o] - 1 + 2*P) % P;
                        if (d < best_d) begin
                            best_d   = d;
                            m_win[o] = j;
                        end
                    end
                end
            end
            if (m_win[o] >= 0) begin
                e_gdp[bitpos(m_win[o], o)] = 1'b1;
                e_ing[m_win[o]] = 1'b1;
            end
        end
        check("gdp", gdp, e_gdp);
        check("ing", ing, e_ing);
        check("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int o = 0; o < P; o++) begin
                if (m_win[o] < 0) continue;
                if (m_locked[o]) begin
                    if (tail[m_win[o]]) m_locked[o] = 1'b0;
                end else begin
                    m_rr[o] = m_win[o];
                    if (!tail[m_win[o]]) begin
                        m_locked[o] = 1'b1;
                        m_owner[o]  = m_win[o];
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int o;
        valid = '0; hdr = '0; tail = '0; dest = '0; ready = '1;
        s_valid = '0; s_hdr = '0; s_tail = '0; s_dest = '0; s_ready = '1;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state, with a request present that must not be granted.
        send(1, 0, 1'b1, 1'b1);
        eval_cycle();
        check("rst_ing", ing, 0);
        tick();
        reset = 1'b0;
        clr_all();

        // Single-flit packets from 1,2,3 to output 0 rotate and never lock.
        send(1, 0, 1'b1, 1'b1);
        send(2, 0, 1'b1, 1'b1);
        send(3, 0, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            eval_cycle();
            check("t1_order", ing, 1 << (1 + c % 3));
            if (c == 0) check("t1_field1", gdp[7:4], 4'b0001);
            check("t1_busy0", busy[0], 1'b0);
            tick();
        end
        clr_all();

        // 4-flit packet from input 4 to output 2 holds off input 0's head.
        send(4, 2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            eval_cycle();
            check("t2_owner", ing, 5'b10000);
            check("t2_busy2", busy[2], (c > 0));
            tick();
            send(4, 2, 1'b0, (c == 2));
            send(0, 2, 1'b1, 1'b1);
        end
        clr(4);
        eval_cycle();
        check("t2_next", ing, 5'b00001);
        tick();
        clr_all();

        // Credit stall on locked output 1 (owner 3), competitor input 0 waiting.
        send(3, 1, 1'b1, 1'b0);
        eval_cycle();
        check("t3_head", ing, 5'b01000);
        tick();
        send(3, 1, 1'b0, 1'b0);
        send(0, 1, 1'b1, 1'b1);
        ready[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            eval_cycle();
            check("t3_stall", ing, 0);
            check("t3_busy", busy[1], 1'b1);
            tick();
        end
        ready[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            send(3, 1, 1'b0, (c == 2));
            eval_cycle();
            check("t3_resume", ing, 5'b01000);
            tick();
        end
        clr(3);
        eval_cycle();
        check("t3_next", ing, 5'b00001);
        tick();
        clr_all();

        // Owner bubbles: nobody else may use output 1.
        send(3, 1, 1'b1, 1'b0);
        eval_cycle();
        tick();
        clr(3);
        send(0, 1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            eval_cycle();
            check("t4_bubble", ing, 0);
            check("t4_busy", busy[1], 1'b1);
            tick();
        end
        send(3, 1, 1'b0, 1'b1);
        eval_cycle();
        check("t4_tail", ing, 5'b01000);
        tick();
        clr(3);
        eval_cycle();
        check("t4_next", ing, 5'b00001);
        tick();
        clr_all();

        // Reset mid-packet drops the lock; lowest eligible head wins afterwards.
        send(4, 2, 1'b1, 1'b0);
        eval_cycle();
        tick();
        send(4, 2, 1'b0, 1'b0);
        send(1, 2, 1'b1, 1'b1);
        send(0, 2, 1'b1, 1'b1);
        eval_cycle();
        check("t5_locked", ing, 5'b10000);
        tick();
        reset = 1'b1;
        eval_cycle();
        check("t5_rst_ing", ing, 0);
        check("t5_rst_gdp", gdp, 0);
        tick();
        reset = 1'b0;
        eval_cycle();
        check("t5_after", ing, 5'b00001);
        check("t5_old_owner", ing[4], 1'b0);
        tick();
        clr_all();

        // Self-loop build: input 2 to its own output 2.
        s_valid[2] = 1'b1;
        s_hdr[2]   = 1'b1;
        s_tail[2]  = 1'b1;
        s_dest[14:10] = 5'b00100;
        #1;
        check("t6_field2", s_gdp[14:10], 5'b00100);
        check("t6_ing", s_ing, 5'b00100);
        @(negedge clk);
        s_valid = '0;
        s_dest  = '0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < P; j++) begin
                o = $urandom_range(0, P - 2);
                if (o >= j) o++;
                clr(j);
                if ($urandom_range(0, 3) != 0) send(j, o, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
                ready[j] = ($urandom_range(0, 4) != 0);
            end
            eval_cycle();
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
